// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM stage buffer.
package ex_mem_pkg;

  // Bit positions inside each flag set
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  // Default widths
  localparam int DEF_DATA_W = 64;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_M_W    = 5;
  localparam int DEF_WB_W   = 2;
  localparam int DEF_FLAG_W = 4;
  localparam int DEF_CNT_W  = 8;

  // One stage entry at the default widths; field order matches the flat payload packing
  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_M_W-1:0]    m;
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_FLAG_W-1:0] alu_flags;
    logic [DEF_FLAG_W-1:0] reg_flags;
  } entry_t;

  // Total payload bits for an arbitrary width configuration
  function automatic int entry_width(int data_w, int rd_w, int m_w, int wb_w, int flag_w);
    return 3 * data_w + rd_w + m_w + wb_w + 2 * flag_w;
  endfunction

endpackage

// File: rtl/ex_mem_stage_buf_slot.sv
// One held entry: valid bit plus payload, with load and clear (clear wins).
module stage_slot
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  // Next state: clear drops valid but keeps the payload so it can be observed as held data
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  // Entry storage, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX/MEM pipeline stage with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module ex_mem_stage_buf
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int M_W    = DEF_M_W,
  parameter int WB_W   = DEF_WB_W,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [M_W-1:0]    in_m,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [FLAG_W-1:0] in_alu_flags,
  input  logic [FLAG_W-1:0] in_reg_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_addr,
  output logic [RD_W-1:0]   out_rd,
  output logic [M_W-1:0]    out_m,
  output logic [WB_W-1:0]   out_wb,
  output logic [FLAG_W-1:0] out_alu_flags,
  output logic [FLAG_W-1:0] out_reg_flags,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = entry_width(DATA_W, RD_W, M_W, WB_W, FLAG_W);

  logic [PAY_W-1:0] in_pay, main_pay, main_d, skid_pay;
  logic             main_valid, main_load, main_clr, skid_valid;
  logic             accept, main_free;
  logic [M_W-1:0]   m_raw;
  logic [WB_W-1:0]  wb_raw;
  logic [CNT_W-1:0] stall_d, stall_q;

  assign in_pay    = {in_alu, in_wdata, in_addr, in_rd, in_m, in_wb, in_alu_flags, in_reg_flags};
  assign accept    = in_valid & in_ready;
  assign main_free = !main_valid | out_ready;

  if (SKID != 0) begin : g_skid
    logic skid_load, skid_clr;

    // Skid only captures when main is blocked; it always empties into main once main frees up
    always_comb begin
      skid_load = !flush & accept & !main_free;
      skid_clr  = flush | main_free;
    end

    stage_slot #(.W(PAY_W)) u_skid (
      .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_load),
      .d(in_pay), .valid(skid_valid), .q(skid_pay)
    );

    // Ready comes straight from the skid flop, so out_ready never reaches in_ready
    assign in_ready = !skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_pay   = '0;
    assign in_ready   = !main_valid | out_ready;
  end

  // Main entry refills from skid first to keep FIFO order, otherwise from the input
  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = in_pay;
    if (flush) begin
      main_clr = 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_load = 1'b1;
        main_d    = skid_pay;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clr = 1'b1;
      end
    end
  end

  stage_slot #(.W(PAY_W)) u_main (
    .clk(clk), .rst(rst), .clr(main_clr), .load(main_load),
    .d(main_d), .valid(main_valid), .q(main_pay)
  );

  // Stall counter: counts held-but-not-taken cycles, sticks at all-ones
  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign {out_alu, out_wdata, out_addr, out_rd, m_raw, wb_raw, out_alu_flags, out_reg_flags} = main_pay;
  assign out_valid = main_valid;
  assign out_m     = main_valid ? m_raw  : '0;
  assign out_wb    = main_valid ? wb_raw : '0;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench: three instances (SKID=1, SKID=0, SKID=1 with CNT_W=3) share one stimulus stream.
module tb_ex_mem_stage_buf;
  import ex_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  entry_t din = '0;

  logic        o_ir [3];
  logic        o_valid [3];
  logic [63:0] o_alu [3];
  logic [63:0] o_wdata [3];
  logic [63:0] o_addr [3];
  logic [4:0]  o_rd [3];
  logic [4:0]  o_m [3];
  logic [1:0]  o_wb [3];
  logic [3:0]  o_af [3];
  logic [3:0]  o_rf [3];
  logic [7:0]  o_stall [2];
  logic [2:0]  stall3;

  int checks = 0;
  int errors = 0;

  // Reference model: each instance is an ordered queue of held entries
  entry_t m_ent [3][2];
  int     m_cnt [3];
  int     m_stall [3];
  entry_t m_last [3];
  int     m_max [3] = '{255, 255, 7};

  always #5 clk = ~clk;

  ex_mem_stage_buf #(.SKID(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ir[0]),
    .in_alu(din.alu), .in_wdata(din.wdata), .in_addr(din.addr), .in_rd(din.rd),
    .in_m(din.m), .in_wb(din.wb), .in_alu_flags(din.alu_flags), .in_reg_flags(din.reg_flags),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_alu(o_alu[0]), .out_wdata(o_wdata[0]),
    .out_addr(o_addr[0]), .out_rd(o_rd[0]), .out_m(o_m[0]), .out_wb(o_wb[0]),
    .out_alu_flags(o_af[0]), .out_reg_flags(o_rf[0]), .stall_cnt(o_stall[0]));

  ex_mem_stage_buf #(.SKID(0), .CNT_W(8)) u_d0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ir[1]),
    .in_alu(din.alu), .in_wdata(din.wdata), .in_addr(din.addr), .in_rd(din.rd),
    .in_m(din.m), .in_wb(din.wb), .in_alu_flags(din.alu_flags), .in_reg_flags(din.reg_flags),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_alu(o_alu[1]), .out_wdata(o_wdata[1]),
    .out_addr(o_addr[1]), .out_rd(o_rd[1]), .out_m(o_m[1]), .out_wb(o_wb[1]),
    .out_alu_flags(o_af[1]), .out_reg_flags(o_rf[1]), .stall_cnt(o_stall[1]));

  ex_mem_stage_buf #(.SKID(1), .CNT_W(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ir[2]),
    .in_alu(din.alu), .in_wdata(din.wdata), .in_addr(din.addr), .in_rd(din.rd),
    .in_m(din.m), .in_wb(din.wb), .in_alu_flags(din.alu_flags), .in_reg_flags(din.reg_flags),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_alu(o_alu[2]), .out_wdata(o_wdata[2]),
    .out_addr(o_addr[2]), .out_rd(o_rd[2]), .out_m(o_m[2]), .out_wb(o_wb[2]),
    .out_alu_flags(o_af[2]), .out_reg_flags(o_rf[2]), .stall_cnt(stall3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] alu);
    in_valid       = v;
    din.alu        = alu;
    din.wdata      = ~alu;
    din.addr       = alu + 64'h100;
    din.rd         = alu[4:0];
    din.m          = 5'h15;
    din.wb         = 2'h3;
    din.alu_flags  = alu[3:0];
    din.reg_flags  = 4'hA;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_stall[i] = 0; m_last[i] = '0;
    end
  endtask

  function automatic logic model_ready(int i);
    if (i == 1) return (m_cnt[i] == 0) || out_ready;
    return m_cnt[i] < 2;
  endfunction

  // Advance the model by one edge using the inputs currently applied
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic r;
      r = model_ready(i);
      if (m_cnt[i] > 0 && !out_ready && m_stall[i] < m_max[i]) m_stall[i]++;
      if (flush) begin
        m_cnt[i] = 0;
      end else begin
        if (m_cnt[i] > 0 && out_ready) begin
          m_ent[i][0] = m_ent[i][1];
          m_cnt[i]--;
        end
        if (in_valid && r) begin
          m_ent[i][m_cnt[i]] = din;
          m_cnt[i]++;
        end
      end
      if (m_cnt[i] > 0) m_last[i] = m_ent[i][0];
    end
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o_valid[0] !== 1'b0 || o_m[0] !== 5'h0 || o_wb[0] !== 2'h0) begin errors++;
      $display("FAIL reset_out got v=%b m=%h wb=%h exp 0/0/0", o_valid[0], o_m[0], o_wb[0]); end
    checks++; if (o_stall[0] !== 8'h0 || o_alu[0] !== 64'h0) begin errors++;
      $display("FAIL reset_regs got stall=%h alu=%h exp 0/0", o_stall[0], o_alu[0]); end
    rst = 1'b1;
    tick();
    checks++; if (o_ir[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ir[0]); end
    // Fill both entries, then reset mid-cycle
    out_ready = 1'b0;
    set_in(1'b1, 64'hA1); tick();
    set_in(1'b1, 64'hB2); tick();
    checks++; if (o_valid[0] !== 1'b1 || o_ir[0] !== 1'b0 || o_stall[0] !== 8'd1) begin errors++;
      $display("FAIL prereset_full got v=%b ir=%b stall=%0d exp 1/0/1", o_valid[0], o_ir[0], o_stall[0]); end
    #2; rst = 1'b0; #1;
    checks++; if (o_valid[0] !== 1'b0 || o_m[0] !== 5'h0 || o_wb[0] !== 2'h0 || o_stall[0] !== 8'h0) begin errors++;
      $display("FAIL async_reset got v=%b m=%h wb=%h stall=%0d exp 0/0/0/0", o_valid[0], o_m[0], o_wb[0], o_stall[0]); end
    #1; rst = 1'b1;
    set_in(1'b0, 64'h0); out_ready = 1'b1;
    tick();
    checks++; if (o_valid[0] !== 1'b0 || o_valid[2] !== 1'b0) begin errors++;
      $display("FAIL post_reset_empty got v=%b/%b exp 0/0", o_valid[0], o_valid[2]); end
  endtask

  task automatic test_stream();
    logic [63:0] vals [3];
    vals[0] = 64'h10; vals[1] = 64'h20; vals[2] = 64'h30;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, vals[k]); #1;
      checks++; if (o_ir[0] !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", k, o_ir[0]); end
      tick();
      checks++; if (o_valid[0] !== 1'b1 || o_alu[0] !== vals[k]) begin errors++;
        $display("FAIL stream_out[%0d] got v=%b alu=%h exp 1/%h", k, o_valid[0], o_alu[0], vals[k]); end
    end
    set_in(1'b0, 64'h0);
    tick();
    checks++; if (o_valid[0] !== 1'b0 || o_m[0] !== 5'h0 || o_wb[0] !== 2'h0 || o_alu[0] !== 64'h30) begin errors++;
      $display("FAIL stream_bubble got v=%b m=%h wb=%h alu=%h exp 0/0/0/30", o_valid[0], o_m[0], o_wb[0], o_alu[0]); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(1'b1, 64'hA); tick();
    checks++; if (o_alu[0] !== 64'hA || o_ir[0] !== 1'b1) begin errors++;
      $display("FAIL bp_a got alu=%h ir=%b exp a/1", o_alu[0], o_ir[0]); end
    set_in(1'b1, 64'hB); tick();
    checks++; if (o_alu[0] !== 64'hA || o_ir[0] !== 1'b0 || o_stall[0] !== 8'd1) begin errors++;
      $display("FAIL bp_b got alu=%h ir=%b stall=%0d exp a/0/1", o_alu[0], o_ir[0], o_stall[0]); end
    set_in(1'b1, 64'hC); tick();
    checks++; if (o_alu[0] !== 64'hA || o_ir[0] !== 1'b0 || o_stall[0] !== 8'd2) begin errors++;
      $display("FAIL bp_hold got alu=%h ir=%b stall=%0d exp a/0/2", o_alu[0], o_ir[0], o_stall[0]); end
    out_ready = 1'b1; tick();
    checks++; if (o_valid[0] !== 1'b1 || o_alu[0] !== 64'hB || o_ir[0] !== 1'b1) begin errors++;
      $display("FAIL bp_out_b got v=%b alu=%h ir=%b exp 1/b/1", o_valid[0], o_alu[0], o_ir[0]); end
    tick();
    checks++; if (o_valid[0] !== 1'b1 || o_alu[0] !== 64'hC) begin errors++;
      $display("FAIL bp_out_c got v=%b alu=%h exp 1/c", o_valid[0], o_alu[0]); end
    set_in(1'b0, 64'h0); tick();
    checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", o_valid[0]); end
  endtask

  task automatic test_flush();
    logic [7:0] s;
    out_ready = 1'b0;
    set_in(1'b1, 64'h111); tick();
    set_in(1'b1, 64'h222); tick();
    checks++; if (o_ir[0] !== 1'b0 || o_valid[1] !== 1'b1) begin errors++;
      $display("FAIL flush_prefill got ir=%b v1=%b exp 0/1", o_ir[0], o_valid[1]); end
    s = o_stall[0];
    set_in(1'b1, 64'h333); flush = 1'b1; tick();
    flush = 1'b0;
    checks++; if (o_valid[0] !== 1'b0 || o_m[0] !== 5'h0 || o_wb[0] !== 2'h0 || o_ir[0] !== 1'b1) begin errors++;
      $display("FAIL flush_clear got v=%b m=%h wb=%h ir=%b exp 0/0/0/1", o_valid[0], o_m[0], o_wb[0], o_ir[0]); end
    checks++; if (o_stall[0] !== s + 8'd1 || o_valid[1] !== 1'b0) begin errors++;
      $display("FAIL flush_stall got stall=%0d v1=%b exp %0d/0", o_stall[0], o_valid[1], s + 8'd1); end
    set_in(1'b0, 64'h0); out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_no_output[%0d] got %b exp 0", k, o_valid[0]); end
    end
    set_in(1'b1, 64'h444); flush = 1'b1; #1;
    checks++; if (o_ir[0] !== 1'b1) begin errors++; $display("FAIL flush_accept_ready got %b exp 1", o_ir[0]); end
    tick();
    flush = 1'b0; set_in(1'b0, 64'h0);
    checks++; if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0) begin errors++;
      $display("FAIL flush_discard got v=%b/%b exp 0/0", o_valid[0], o_valid[1]); end
  endtask

  task automatic test_stall_sat();
    apply_reset();
    out_ready = 1'b0;
    set_in(1'b1, 64'h55); tick();
    set_in(1'b0, 64'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (int'(stall3) !== ((k < 7) ? k : 7)) begin errors++;
        $display("FAIL stall_sat[%0d] got %0d exp %0d", k, stall3, (k < 7) ? k : 7); end
    end
  endtask

  task automatic test_skid0();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 64'h70 + 64'(k)); #1;
      checks++; if (o_ir[1] !== 1'b1) begin errors++; $display("FAIL s0_ready[%0d] got %b exp 1", k, o_ir[1]); end
      tick();
      checks++; if (o_valid[1] !== 1'b1 || o_alu[1] !== 64'h70 + 64'(k)) begin errors++;
        $display("FAIL s0_tput[%0d] got v=%b alu=%h exp 1/%h", k, o_valid[1], o_alu[1], 64'h70 + 64'(k)); end
    end
    out_ready = 1'b0; #1;
    checks++; if (o_ir[1] !== 1'b0) begin errors++; $display("FAIL s0_follow_lo got %b exp 0", o_ir[1]); end
    out_ready = 1'b1; #1;
    checks++; if (o_ir[1] !== 1'b1) begin errors++; $display("FAIL s0_follow_hi got %b exp 1", o_ir[1]); end
    set_in(1'b0, 64'h0);
  endtask

  task automatic test_random();
    entry_t got, exp;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 55);
      flush     = ($urandom_range(99) < 5);
      din       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom[19:0]};
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++; if (o_ir[i] !== model_ready(i)) begin errors++;
          $display("FAIL rnd_in_ready[%0d] cyc %0d got %b exp %b", i, n, o_ir[i], model_ready(i)); end
      end
      model_step();
      tick();
      for (int i = 0; i < 3; i++) begin
        got = {o_alu[i], o_wdata[i], o_addr[i], o_rd[i], o_m[i], o_wb[i], o_af[i], o_rf[i]};
        exp = m_last[i];
        if (m_cnt[i] == 0) begin exp.m = '0; exp.wb = '0; end
        checks++; if (o_valid[i] !== (m_cnt[i] > 0) || got !== exp) begin errors++;
          $display("FAIL rnd_out[%0d] cyc %0d got v=%b %h exp v=%b %h", i, n, o_valid[i], got, m_cnt[i] > 0, exp); end
      end
      checks++; if (int'(o_stall[0]) !== m_stall[0] || int'(o_stall[1]) !== m_stall[1] || int'(stall3) !== m_stall[2]) begin errors++;
        $display("FAIL rnd_stall cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, o_stall[0], o_stall[1], stall3,
                 m_stall[0], m_stall[1], m_stall[2]); end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_skid0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
